// File: rtl/firmware_boot_sequencer.sv
// Firmware boot sequencer: holds the CPU in reset while the firmware ROM and
// the six vector bytes are summed and the reset vector is captured, then
// either hands the ROM port to the CPU (RUN) or parks with the CPU held (FAULT).
module firmware_boot_sequencer #(
  parameter int FIRMWARE_SIZE = 16,
  parameter int ADDR_W        = $clog2(FIRMWARE_SIZE),
  parameter bit CHECK_EN      = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rescan_i,
  input  logic [7:0]        expected_sum_i,
  input  logic [ADDR_W-1:0] cpu_address_i,
  input  logic              cpu_select_firmware_i,
  input  logic              cpu_select_vectors_i,
  output logic [7:0]        cpu_data_o,
  output logic [ADDR_W-1:0] rom_address_o,
  output logic              rom_select_firmware_o,
  output logic              rom_select_vectors_o,
  input  logic [7:0]        rom_data_i,
  output logic              cpu_rst_o,
  output logic [7:0]        checksum_o,
  output logic [15:0]       rst_vector_o,
  output logic              done_o,
  output logic              fault_o
);

  typedef enum logic [2:0] {
    ST_SCAN  = 3'd0,
    ST_VEC   = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FIRMWARE_SIZE - 1);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        vidx_r;
  logic [7:0]        sum_r;
  logic [15:0]       rst_vector_r;
  logic              cpu_rst_r;
  logic              done_r;
  logic              fault_r;
  logic [ADDR_W-1:0] vec_addr_s;

  // Vector bytes sit at the top of the address space: upper bits all ones,
  // low three bits walk 2..7 so the ROM sees ...A through ...F.
  assign vec_addr_s = ({ADDR_W{1'b1}} << 3) | ADDR_W'(vidx_r + 3'd2);

  // Next-state decode for the boot sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_SCAN: begin
        if (addr_r == LAST_ADDR) state_s = ST_VEC;
        else                     state_s = ST_SCAN;
      end
      ST_VEC: begin
        if (vidx_r == 3'd5) state_s = ST_CHECK;
        else                state_s = ST_VEC;
      end
      ST_CHECK: begin
        if ((CHECK_EN == 1'b0) || (sum_r == expected_sum_i)) state_s = ST_RUN;
        else                                                 state_s = ST_FAULT;
      end
      ST_RUN: begin
        if (rescan_i) state_s = ST_SCAN;
        else          state_s = ST_RUN;
      end
      ST_FAULT: begin
        if (rescan_i) state_s = ST_SCAN;
        else          state_s = ST_FAULT;
      end
      default: state_s = ST_SCAN;
    endcase
  end

  // State register, scan datapath and registered status decodes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_SCAN;
      addr_r       <= '0;
      vidx_r       <= 3'd0;
      sum_r        <= 8'h00;
      rst_vector_r <= 16'h0000;
      cpu_rst_r    <= 1'b1;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cpu_rst_r <= (state_s != ST_RUN);
      done_r    <= (state_s == ST_RUN);
      fault_r   <= (state_s == ST_FAULT);
      case (state_r)
        ST_SCAN: begin
          sum_r  <= sum_r + rom_data_i;
          addr_r <= addr_r + ADDR_W'(1);
          vidx_r <= 3'd0;
        end
        ST_VEC: begin
          sum_r  <= sum_r + rom_data_i;
          vidx_r <= vidx_r + 3'd1;
          if (vidx_r == 3'd2) rst_vector_r[7:0]  <= rom_data_i;
          if (vidx_r == 3'd3) rst_vector_r[15:8] <= rom_data_i;
        end
        ST_RUN, ST_FAULT: begin
          if (rescan_i) begin
            sum_r  <= 8'h00;
            addr_r <= '0;
            vidx_r <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // ROM port ownership and CPU read-data gating.
  always_comb begin
    rom_address_o         = addr_r;
    rom_select_firmware_o = 1'b0;
    rom_select_vectors_o  = 1'b0;
    cpu_data_o            = 8'h00;
    case (state_r)
      ST_SCAN: begin
        rom_select_firmware_o = 1'b1;
      end
      ST_VEC: begin
        rom_select_vectors_o = 1'b1;
        rom_address_o        = vec_addr_s;
      end
      ST_RUN: begin
        rom_address_o         = cpu_address_i;
        rom_select_firmware_o = cpu_select_firmware_i;
        rom_select_vectors_o  = cpu_select_vectors_i;
        if (cpu_select_firmware_i || cpu_select_vectors_i) cpu_data_o = rom_data_i;
        else                                               cpu_data_o = 8'h00;
      end
      default: ;
    endcase
  end

  assign cpu_rst_o    = cpu_rst_r;
  assign done_o       = done_r;
  assign fault_o      = fault_r;
  assign checksum_o   = sum_r;
  assign rst_vector_o = rst_vector_r;

endmodule

// File: tb/tb_firmware_boot_sequencer.sv
// Bench for firmware_boot_sequencer: 16-byte image 0x01..0x10 with vectors
// {00,80,00,C0,00,E0}; one checked instance and one with checking disabled.
module tb_firmware_boot_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rescan = 1'b0;
  logic [7:0] expected_sum = 8'h00;
  logic [3:0] cpu_addr = 4'h5;
  logic       cpu_fw = 1'b1;
  logic       cpu_vec = 1'b0;

  logic [7:0]  cpu_data0, rom_data0, checksum0;
  logic [3:0]  rom_addr0;
  logic        rom_fw0, rom_vec0, cpu_rst0, done0, fault0;
  logic [15:0] rst_vec0;

  logic [7:0]  cpu_data1, rom_data1, checksum1;
  logic [3:0]  rom_addr1;
  logic        rom_fw1, rom_vec1, cpu_rst1, done1, fault1;
  logic [15:0] rst_vec1;

  int total = 0;
  int bad = 0;
  logic [7:0]  gold_sum;
  logic [15:0] gold_vec;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  // ROM model; undriven selects return a marker byte so stray reads show up.
  function automatic logic [7:0] rom_read(input logic [3:0] a, input logic fw, input logic vec);
    logic [7:0] d;
    if (fw) d = {4'h0, a} + 8'h01;
    else if (vec) begin
      case (a)
        4'hB:    d = 8'h80;
        4'hD:    d = 8'hC0;
        4'hF:    d = 8'hE0;
        default: d = 8'h00;
      endcase
    end else d = 8'h5A;
    return d;
  endfunction

  assign rom_data0 = rom_read(rom_addr0, rom_fw0, rom_vec0);
  assign rom_data1 = rom_read(rom_addr1, rom_fw1, rom_vec1);

  firmware_boot_sequencer #(.FIRMWARE_SIZE(16), .CHECK_EN(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst), .rescan_i(rescan), .expected_sum_i(expected_sum),
    .cpu_address_i(cpu_addr), .cpu_select_firmware_i(cpu_fw), .cpu_select_vectors_i(cpu_vec),
    .cpu_data_o(cpu_data0), .rom_address_o(rom_addr0), .rom_select_firmware_o(rom_fw0),
    .rom_select_vectors_o(rom_vec0), .rom_data_i(rom_data0), .cpu_rst_o(cpu_rst0),
    .checksum_o(checksum0), .rst_vector_o(rst_vec0), .done_o(done0), .fault_o(fault0));

  firmware_boot_sequencer #(.FIRMWARE_SIZE(16), .CHECK_EN(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .rescan_i(1'b0), .expected_sum_i(8'h00),
    .cpu_address_i(4'h0), .cpu_select_firmware_i(1'b0), .cpu_select_vectors_i(1'b0),
    .cpu_data_o(cpu_data1), .rom_address_o(rom_addr1), .rom_select_firmware_o(rom_fw1),
    .rom_select_vectors_o(rom_vec1), .rom_data_i(rom_data1), .cpu_rst_o(cpu_rst1),
    .checksum_o(checksum1), .rst_vector_o(rst_vec1), .done_o(done1), .fault_o(fault1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count rising edges until u0 leaves reset hold or faults; bounded.
  task automatic wait_boot(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (!cpu_rst0 || fault0) break;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_rst"}, cpu_rst0, 1);
    check({tag, "_done"}, done0, 0);
    check({tag, "_fault"}, fault0, 0);
    check({tag, "_sum"}, checksum0, 0);
    check({tag, "_rom_addr"}, rom_addr0, 0);
    check({tag, "_rom_fw"}, rom_fw0, 1);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic       fw;
    logic       vec;
    logic [7:0] exp;
  } rd_t;

  rd_t tbl[8];
  int  n;
  logic [7:0] got, want;

  initial begin
    tbl[0] = '{4'h5, 1'b1, 1'b0, 8'h06};
    tbl[1] = '{4'h0, 1'b1, 1'b0, 8'h01};
    tbl[2] = '{4'hF, 1'b1, 1'b0, 8'h10};
    tbl[3] = '{4'hC, 1'b0, 1'b1, 8'h00};
    tbl[4] = '{4'hD, 1'b0, 1'b1, 8'hC0};
    tbl[5] = '{4'hF, 1'b0, 1'b1, 8'hE0};
    tbl[6] = '{4'hB, 1'b0, 1'b1, 8'h80};
    tbl[7] = '{4'h3, 1'b0, 1'b0, 8'h00};

    gold_sum = 8'h00;
    for (int a = 0; a < 16; a++) gold_sum = gold_sum + rom_read(4'(a), 1'b1, 1'b0);
    for (int a = 10; a < 16; a++) gold_sum = gold_sum + rom_read(4'(a), 1'b0, 1'b1);
    gold_vec = {rom_read(4'hD, 1'b0, 1'b1), rom_read(4'hC, 1'b0, 1'b1)};
    expected_sum = gold_sum;

    // Reset state, with a CPU select held high to show it is ignored.
    #12;
    check_reset_vals("reset");
    check("reset_vec", rst_vec0, 0);
    check("reset_cpu_data", cpu_data0, 0);

    // First boot: RUN at edge 23.
    @(negedge clk) rst = 1'b0;
    wait_boot(n);
    check("boot_latency", n, 23);
    check("boot_done", done0, 1);
    check("boot_fault", fault0, 0);
    check("boot_sum", checksum0, gold_sum);
    check("boot_vector", rst_vec0, gold_vec);
    check("nochk_done", done1, 1);
    check("nochk_sum", checksum1, gold_sum);

    // CPU reads through the ROM port in RUN (scoreboarded).
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cpu_addr = tbl[i].addr;
      cpu_fw   = tbl[i].fw;
      cpu_vec  = tbl[i].vec;
      exp_q.push_back(tbl[i].exp);
      #2;
      got  = cpu_data0;
      want = exp_q.pop_front();
      check($sformatf("run_read%0d", i), got, want);
      check($sformatf("run_addr%0d", i), rom_addr0, tbl[i].addr);
    end
    check("run_stable_sum", checksum0, gold_sum);

    // Rescan from RUN.
    @(negedge clk) rescan = 1'b1;
    @(posedge clk);
    #1 rescan = 1'b0;
    check("rescan_cpu_rst", cpu_rst0, 1);
    check("rescan_done", done0, 0);
    check("rescan_sum", checksum0, 0);
    check("rescan_vec_held", rst_vec0, gold_vec);
    wait_boot(n);
    check("rescan_latency", n, 23);
    check("rescan_done2", done0, 1);
    check("rescan_sum2", checksum0, gold_sum);

    // Reset pulsed mid-scan.
    @(negedge clk) rescan = 1'b1;
    @(posedge clk);
    #1 rescan = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk) rst = 1'b0;
    wait_boot(n);
    check("midrst_latency", n, 23);
    check("midrst_done", done0, 1);
    check("midrst_sum", checksum0, gold_sum);
    check("midrst_vec", rst_vec0, gold_vec);

    // Mismatching golden sum: FAULT, CPU held, reads blocked.
    @(negedge clk);
    expected_sum = gold_sum ^ 8'hFF;
    rescan = 1'b1;
    @(posedge clk);
    #1 rescan = 1'b0;
    wait_boot(n);
    check("fault_latency", n, 23);
    check("fault_flag", fault0, 1);
    check("fault_cpu_rst", cpu_rst0, 1);
    check("fault_done", done0, 0);
    @(negedge clk);
    cpu_addr = 4'h5; cpu_fw = 1'b1; cpu_vec = 1'b0;
    #2;
    check("fault_cpu_data", cpu_data0, 0);
    check("fault_rom_fw", rom_fw0, 0);
    check("fault_rom_vec", rom_vec0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("fault_parked", fault0, 1);
    check("fault_sum", checksum0, gold_sum);

    // Rescan from FAULT with the right golden sum.
    @(negedge clk);
    expected_sum = gold_sum;
    rescan = 1'b1;
    @(posedge clk);
    #1 rescan = 1'b0;
    check("refault_cpu_rst", cpu_rst0, 1);
    check("refault_fault", fault0, 0);
    wait_boot(n);
    check("recover_latency", n, 23);
    check("recover_done", done0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
